// File: rtl/ws2812_strip_driver.sv
// WS2812 serial LED driver: streams LED_NUM pixel words through a one-entry
// holding buffer, emits timed high/low bit cells and ends each frame with a latch-low period.
module ws2812_strip_driver #(
   parameter int CLK_FRE   = 27_000_000,
   parameter int LED_NUM   = 8,
   parameter int BIT_WIDTH = 24,
   parameter int T1H_NS    = 850,
   parameter int T1L_NS    = 400,
   parameter int T0H_NS    = 400,
   parameter int T0L_NS    = 850,
   parameter int RESET_US  = 80
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [BIT_WIDTH-1:0] pix_data,
   input  logic                 pix_valid,
   output logic                 pix_ready,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 underrun,
   output logic                 WS2812
);

   function automatic int ns_to_cyc(input int ns);
      int c;
      c = ((CLK_FRE / 1_000_000) * ns) / 1000;
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int C1H      = ns_to_cyc(T1H_NS);
   localparam int C1L      = ns_to_cyc(T1L_NS);
   localparam int C0H      = ns_to_cyc(T0H_NS);
   localparam int C0L      = ns_to_cyc(T0L_NS);
   localparam int CRES_RAW = (CLK_FRE / 1_000_000) * RESET_US;
   localparam int CRES_CYC = (CRES_RAW < 1) ? 1 : CRES_RAW;
   localparam int MAX_CYC  = max2(max2(max2(C1H, C1L), max2(C0H, C0L)), CRES_CYC);
   localparam int CNT_W    = $clog2(MAX_CYC + 1);
   localparam int PIX_W    = $clog2(LED_NUM + 1);
   localparam int BIT_W    = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;

   // Counters load with (cycles - 1) and run down to zero.
   localparam logic [CNT_W-1:0] K_1H    = CNT_W'(C1H - 1);
   localparam logic [CNT_W-1:0] K_1L    = CNT_W'(C1L - 1);
   localparam logic [CNT_W-1:0] K_0H    = CNT_W'(C0H - 1);
   localparam logic [CNT_W-1:0] K_0L    = CNT_W'(C0L - 1);
   localparam logic [CNT_W-1:0] K_RES   = CNT_W'(CRES_CYC - 1);
   localparam logic [CNT_W-1:0] K_ONE   = CNT_W'(1);
   localparam logic [PIX_W-1:0] LED_CNT = PIX_W'(LED_NUM);
   localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BIT_WIDTH - 1);
   localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

   function automatic logic [CNT_W-1:0] high_cnt(input logic b);
      return b ? K_1H : K_0H;
   endfunction

   function automatic logic [CNT_W-1:0] low_cnt(input logic b);
      return b ? K_1L : K_0L;
   endfunction

   typedef enum logic [2:0] {IDLE, FETCH, HIGH, LOW, LATCH} state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [BIT_W-1:0]     bit_idx;
   logic [PIX_W-1:0]     sent_cnt;
   logic [PIX_W-1:0]     acc_cnt;
   logic                 buf_full;
   logic                 abort;
   logic [BIT_WIDTH-1:0] buf_data;
   logic [BIT_WIDTH-1:0] shreg;
   logic [BIT_WIDTH-1:0] shreg_sh;

   logic             cnt_zero;
   logic             last_bit;
   logic             all_loaded;
   logic             bit_end;
   logic             pix_end;
   logic             load;
   logic             to_latch;
   logic             xfer;
   logic             buf_full_n;
   logic             active_n;
   logic [PIX_W-1:0] acc_n;

   assign shreg_sh   = shreg << 1;
   assign cnt_zero   = (cnt == '0);
   assign last_bit   = (bit_idx == LAST_BIT);
   assign all_loaded = (sent_cnt == LED_CNT);
   assign bit_end    = (state == LOW) & cnt_zero;
   assign pix_end    = bit_end & last_bit;
   assign load       = ((state == FETCH) & buf_full) | (pix_end & ~all_loaded & buf_full);
   assign to_latch   = pix_end & (all_loaded | ~buf_full);
   assign xfer       = pix_valid & pix_ready;
   assign buf_full_n = (buf_full & ~load) | xfer;
   assign acc_n      = acc_cnt + (xfer ? PIX_ONE : '0);
   // pix_ready is computed from next-cycle state so it never offers a full buffer.
   assign active_n   = ((state == IDLE) & start) |
                       (((state == FETCH) | (state == HIGH) | (state == LOW)) & ~to_latch);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         sent_cnt   <= '0;
         acc_cnt    <= '0;
         buf_full   <= 1'b0;
         abort      <= 1'b0;
         busy       <= 1'b0;
         pix_ready  <= 1'b0;
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         WS2812     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         underrun   <= 1'b0;
         acc_cnt    <= acc_n;
         buf_full   <= buf_full_n;
         pix_ready  <= active_n & ~buf_full_n & (acc_n < LED_CNT);
         if (load) sent_cnt <= sent_cnt + PIX_ONE;
         case (state)
            IDLE: begin
               WS2812 <= 1'b0;
               if (start) begin
                  state <= FETCH;
                  busy  <= 1'b1;
                  abort <= 1'b0;
               end
            end
            FETCH: begin
               WS2812 <= 1'b0;
               if (buf_full) begin
                  state   <= HIGH;
                  WS2812  <= 1'b1;
                  bit_idx <= '0;
                  cnt     <= high_cnt(buf_data[BIT_WIDTH-1]);
               end
            end
            HIGH: begin
               if (cnt_zero) begin
                  state  <= LOW;
                  WS2812 <= 1'b0;
                  cnt    <= low_cnt(shreg[BIT_WIDTH-1]);
               end else begin
                  cnt <= cnt - K_ONE;
               end
            end
            LOW: begin
               if (!cnt_zero) begin
                  cnt <= cnt - K_ONE;
               end else if (!last_bit) begin
                  state   <= HIGH;
                  WS2812  <= 1'b1;
                  bit_idx <= bit_idx + BIT_ONE;
                  cnt     <= high_cnt(shreg_sh[BIT_WIDTH-1]);
               end else if (to_latch) begin
                  state      <= LATCH;
                  cnt        <= K_RES;
                  underrun   <= ~all_loaded;
                  abort      <= ~all_loaded;
                  frame_done <= (CRES_CYC == 1) & all_loaded;
               end else begin
                  // Next pixel is waiting: start its first bit with no gap.
                  state   <= HIGH;
                  WS2812  <= 1'b1;
                  bit_idx <= '0;
                  cnt     <= high_cnt(buf_data[BIT_WIDTH-1]);
               end
            end
            LATCH: begin
               WS2812 <= 1'b0;
               if (cnt_zero) begin
                  state    <= IDLE;
                  busy     <= 1'b0;
                  sent_cnt <= '0;
                  acc_cnt  <= '0;
                  buf_full <= 1'b0;
               end else begin
                  cnt        <= cnt - K_ONE;
                  frame_done <= (cnt == K_ONE) & ~abort;
               end
            end
            default: begin
               state  <= IDLE;
               busy   <= 1'b0;
               WS2812 <= 1'b0;
            end
         endcase
      end
   end

   // Pixel data path: holding buffer and MSB-first shift register.
   always_ff @(posedge clk) begin
      if (xfer) buf_data <= pix_data;
      if (load) shreg <= buf_data;
      else if (bit_end && !last_bit) shreg <= shreg_sh;
   end

endmodule
